// File: rtl/dm_host_controller.sv
// Data-memory front end: host loads operands, processor runs on the memory, then results dump to host.
// Latency: memory reads are registered (1 cycle); dump issues one byte every 2 cycles at best.
// Backpressure: load stalls on host_in_valid; a dump byte is held stable on host_out_data until host_out_ready.
module dm_host_controller #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 4096
) (
  input  logic                  clock,
  input  logic                  rst_r,
  input  logic                  host_start,
  input  logic [ADDR_WIDTH-1:0] host_load_len,
  input  logic [ADDR_WIDTH-1:0] host_dump_base,
  input  logic [ADDR_WIDTH-1:0] host_dump_len,
  input  logic [DATA_WIDTH-1:0] host_in_data,
  input  logic                  host_in_valid,
  output logic                  host_in_ready,
  output logic [DATA_WIDTH-1:0] host_out_data,
  output logic                  host_out_valid,
  input  logic                  host_out_ready,
  input  logic                  proc_dm_en,
  input  logic [ADDR_WIDTH-1:0] proc_addr,
  input  logic [DATA_WIDTH-1:0] proc_wdata,
  input  logic                  proc_end,
  output logic [DATA_WIDTH-1:0] proc_rdata,
  output logic [1:0]            proc_status,
  output logic                  proc_rst,
  output logic                  busy
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_DUMP_RD, S_DUMP_OUT, S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_load_len;
  logic [ADDR_WIDTH-1:0] r_dump_base;
  logic [ADDR_WIDTH-1:0] r_dump_len;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_proc_rst;
  logic [DATA_WIDTH-1:0] r_proc_rdata;
  logic [DATA_WIDTH-1:0] r_out_data;

  logic [ADDR_WIDTH-1:0] w_cnt_inc;
  logic [ADDR_WIDTH-1:0] w_dump_addr;
  logic [IW-1:0]         w_proc_idx;
  logic [IW-1:0]         w_dump_idx;
  logic [IW-1:0]         w_load_idx;
  logic                  w_start_ok;
  logic                  w_load_xfer;
  logic                  w_dump_xfer;
  logic                  w_unused_addr_bits;

  // Addresses wrap at ADDR_WIDTH first, then only the low IW bits select a word.
  assign w_cnt_inc   = r_cnt + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  assign w_dump_addr = r_dump_base + r_cnt;
  assign w_proc_idx  = proc_addr[IW-1:0];
  assign w_dump_idx  = w_dump_addr[IW-1:0];
  assign w_load_idx  = r_cnt[IW-1:0];
  assign w_unused_addr_bits = ^{proc_addr[ADDR_WIDTH-1:IW], w_dump_addr[ADDR_WIDTH-1:IW]};

  // A start is only honoured between jobs; a byte offered with the start pulse is not taken.
  assign w_start_ok  = host_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_load_xfer = (r_state == S_LOAD) && host_in_valid;
  assign w_dump_xfer = (r_state == S_DUMP_OUT) && host_out_ready;

  assign proc_rst      = r_proc_rst;
  assign proc_rdata    = r_proc_rdata;
  assign host_out_data = r_out_data;

  // State register.
  always_ff @(posedge clock) begin
    if (rst_r) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (host_start) w_next = (host_load_len == '0) ? S_RUN : S_LOAD;
      end
      S_LOAD: begin
        if (w_load_xfer && (w_cnt_inc == r_load_len)) w_next = S_RUN;
      end
      S_RUN: begin
        if (proc_end) w_next = (r_dump_len == '0) ? S_DONE : S_DUMP_RD;
      end
      S_DUMP_RD: w_next = S_DUMP_OUT;
      S_DUMP_OUT: begin
        if (w_dump_xfer) w_next = (w_cnt_inc == r_dump_len) ? S_DONE : S_DUMP_RD;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    host_in_ready  = 1'b0;
    host_out_valid = 1'b0;
    proc_status    = 2'b11;
    busy           = 1'b1;
    case (r_state)
      S_IDLE: begin
        proc_status = 2'b00;
        busy        = 1'b0;
      end
      S_LOAD: begin
        proc_status   = 2'b01;
        host_in_ready = 1'b1;
      end
      S_RUN:      proc_status = 2'b10;
      S_DUMP_RD:  proc_status = 2'b11;
      S_DUMP_OUT: host_out_valid = 1'b1;
      S_DONE:     busy = 1'b0;
      default: begin
        proc_status = 2'b00;
        busy        = 1'b0;
      end
    endcase
  end

  // Job registers, counter, processor reset and both read ports.
  always_ff @(posedge clock) begin
    if (rst_r) begin
      r_load_len   <= '0;
      r_dump_base  <= '0;
      r_dump_len   <= '0;
      r_cnt        <= '0;
      r_proc_rst   <= 1'b1;
      r_proc_rdata <= '0;
      r_out_data   <= '0;
    end else begin
      r_proc_rst   <= (w_next != S_RUN);
      r_proc_rdata <= r_mem[w_proc_idx];
      if (w_start_ok) begin
        r_load_len  <= host_load_len;
        r_dump_base <= host_dump_base;
        r_dump_len  <= host_dump_len;
        r_cnt       <= '0;
      end else if ((r_state == S_RUN) && proc_end) begin
        r_cnt <= '0;
      end else if (w_load_xfer || w_dump_xfer) begin
        r_cnt <= w_cnt_inc;
      end
      if (r_state == S_DUMP_RD) r_out_data <= r_mem[w_dump_idx];
    end
  end

  // Memory write port: host during LOAD, processor only during RUN; contents survive reset.
  always_ff @(posedge clock) begin
    if (!rst_r) begin
      if (w_load_xfer)                            r_mem[w_load_idx] <= host_in_data;
      else if ((r_state == S_RUN) && proc_dm_en)  r_mem[w_proc_idx] <= proc_wdata;
    end
  end

endmodule

// File: tb/tb_dm_host_controller.sv
// Bench for dm_host_controller: directed scenarios plus randomized jobs.
// Dump bytes are predicted from a reference memory and checked by a separate monitor.
// host_out_ready is stalled and randomized to exercise dump backpressure.
module tb_dm_host_controller;

  logic        clock = 1'b0;
  logic        rst_r;
  logic        host_start;
  logic [15:0] host_load_len, host_dump_base, host_dump_len;
  logic [7:0]  host_in_data;
  logic        host_in_valid, host_in_ready;
  logic [7:0]  host_out_data;
  logic        host_out_valid, host_out_ready;
  logic        proc_dm_en;
  logic [15:0] proc_addr;
  logic [7:0]  proc_wdata;
  logic        proc_end;
  logic [7:0]  proc_rdata;
  logic [1:0]  proc_status;
  logic        proc_rst, busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] ref_mem [4096];
  bit         known   [4096];
  logic [7:0] exp_q[$];

  dm_host_controller dut (
    .clock(clock), .rst_r(rst_r), .host_start(host_start),
    .host_load_len(host_load_len), .host_dump_base(host_dump_base), .host_dump_len(host_dump_len),
    .host_in_data(host_in_data), .host_in_valid(host_in_valid), .host_in_ready(host_in_ready),
    .host_out_data(host_out_data), .host_out_valid(host_out_valid), .host_out_ready(host_out_ready),
    .proc_dm_en(proc_dm_en), .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_end(proc_end),
    .proc_rdata(proc_rdata), .proc_status(proc_status), .proc_rst(proc_rst), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clock) begin
    if (!rst_r && host_out_valid && host_out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL dump_extra: got %0h expected no byte at %0t", host_out_data, $time);
      end else begin
        check("dump_byte", host_out_data, exp_q.pop_front());
      end
    end
  end

  function automatic int idx_of(input logic [15:0] a);
    return int'(a[11:0]);
  endfunction

  task automatic start_job(input logic [15:0] ll, input logic [15:0] db, input logic [15:0] dl);
    host_load_len = ll; host_dump_base = db; host_dump_len = dl;
    host_start = 1'b1;
    host_in_valid = 1'b1; host_in_data = 8'hEE;
    @(posedge clock); #1;
    host_start = 1'b0;
    host_in_valid = 1'b0;
  endtask

  task automatic send_byte(input int idx, input logic [7:0] d, input int gap);
    int t;
    repeat (gap) begin @(posedge clock); #1; end
    host_in_valid = 1'b1; host_in_data = d;
    t = 0;
    while (!host_in_ready && t < 50) begin @(posedge clock); #1; t++; end
    check("load_ready_seen", host_in_ready, 1);
    @(posedge clock); #1;
    host_in_valid = 1'b0;
    ref_mem[idx] = d;
    known[idx] = 1'b1;
  endtask

  task automatic run_cycle(input logic [15:0] a, input bit en, input logic [7:0] d);
    int idx;
    logic [7:0] e;
    bit k;
    idx = idx_of(a);
    e = ref_mem[idx];
    k = known[idx];
    proc_addr = a; proc_dm_en = en; proc_wdata = d;
    @(posedge clock); #1;
    proc_dm_en = 1'b0;
    if (k) check("run_rdata", proc_rdata, e);
    if (en) begin ref_mem[idx] = d; known[idx] = 1'b1; end
  endtask

  task automatic pulse_end(input logic [15:0] db, input logic [15:0] dl);
    for (int i = 0; i < int'(dl); i++) exp_q.push_back(ref_mem[idx_of(db + 16'(i))]);
    proc_end = 1'b1;
    @(posedge clock); #1;
    proc_end = 1'b0;
  endtask

  task automatic wait_done(input bit rnd);
    int t;
    t = 0;
    while (!(proc_status == 2'b11 && !busy) && t < 300) begin
      host_out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clock); #1;
      t++;
    end
    host_out_ready = 1'b0;
    check("done_reached", (t < 300), 1);
    check("dump_drained", exp_q.size(), 0);
    check("done_proc_rst", proc_rst, 1);
  endtask

  initial begin
    logic [15:0] ll, db, dl, a;
    rst_r = 1'b1; host_start = 1'b0; host_load_len = '0; host_dump_base = '0; host_dump_len = '0;
    host_in_data = '0; host_in_valid = 1'b0; host_out_ready = 1'b0;
    proc_dm_en = 1'b0; proc_addr = '0; proc_wdata = '0; proc_end = 1'b0;
    for (int i = 0; i < 4096; i++) begin ref_mem[i] = '0; known[i] = 1'b0; end

    // Reset state
    repeat (2) @(posedge clock); #1;
    check("rst_status", proc_status, 0);
    check("rst_proc_rst", proc_rst, 1);
    check("rst_in_ready", host_in_ready, 0);
    check("rst_out_valid", host_out_valid, 0);
    check("rst_out_data", host_out_data, 0);
    check("rst_rdata", proc_rdata, 0);
    check("rst_busy", busy, 0);
    rst_r = 1'b0;
    @(posedge clock); #1;

    // Load of four bytes with gaps; the byte offered alongside start must not land
    start_job(16'd4, 16'h0010, 16'd2);
    check("load_status", proc_status, 1);
    check("load_busy", busy, 1);
    send_byte(0, 8'h11, 0);
    send_byte(1, 8'h22, 0);
    check("load_status_mid", proc_status, 1);
    send_byte(2, 8'h33, 2);
    send_byte(3, 8'h44, 1);
    check("run_status", proc_status, 2);
    check("run_proc_rst", proc_rst, 0);
    check("run_in_ready", host_in_ready, 0);

    // Processor access, including read-old-on-write
    run_cycle(16'h0010, 1'b1, 8'hAB);
    run_cycle(16'h0011, 1'b1, 8'hCD);
    run_cycle(16'h0001, 1'b0, 8'h00);
    run_cycle(16'h0010, 1'b0, 8'h00);
    run_cycle(16'h0000, 1'b0, 8'h00);
    run_cycle(16'h0020, 1'b1, 8'h01);
    run_cycle(16'h0020, 1'b1, 8'h02);
    run_cycle(16'h0020, 1'b0, 8'h00);

    // Start during RUN is ignored, lengths included
    host_load_len = 16'd7; host_dump_base = 16'h0000; host_dump_len = 16'd5;
    host_start = 1'b1;
    @(posedge clock); #1;
    host_start = 1'b0;
    check("ignored_start_status", proc_status, 2);
    check("ignored_start_rst", proc_rst, 0);

    // Dump with a 3-cycle stall on the first byte
    host_out_ready = 1'b0;
    pulse_end(16'h0010, 16'd2);
    check("dump_rd_status", proc_status, 3);
    check("dump_rd_proc_rst", proc_rst, 1);
    check("dump_rd_busy", busy, 1);
    @(posedge clock); #1;
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", host_out_valid, 1);
      check("stall_data", host_out_data, 8'hAB);
      @(posedge clock); #1;
    end
    wait_done(1'b0);
    check("done_status", proc_status, 3);
    check("done_valid", host_out_valid, 0);

    // Zero lengths
    start_job(16'd0, 16'h0000, 16'd0);
    check("zero_load_run", proc_status, 2);
    check("zero_load_rst", proc_rst, 0);
    pulse_end(16'h0000, 16'd0);
    check("zero_dump_status", proc_status, 3);
    check("zero_dump_busy", busy, 0);
    check("zero_dump_valid", host_out_valid, 0);
    check("zero_dump_rst", proc_rst, 1);

    // Abort mid-load, then a shorter job; processor writes outside RUN are ignored
    start_job(16'd4, 16'h0000, 16'd4);
    send_byte(0, 8'h55, 0);
    send_byte(1, 8'h66, 0);
    rst_r = 1'b1;
    repeat (2) begin @(posedge clock); #1; end
    check("abort_status", proc_status, 0);
    check("abort_proc_rst", proc_rst, 1);
    check("abort_in_ready", host_in_ready, 0);
    check("abort_out_valid", host_out_valid, 0);
    check("abort_busy", busy, 0);
    rst_r = 1'b0;
    @(posedge clock); #1;
    proc_dm_en = 1'b1; proc_addr = 16'h0002; proc_wdata = 8'hFF;
    start_job(16'd2, 16'h0000, 16'd4);
    proc_dm_en = 1'b1;
    send_byte(0, 8'h77, 0);
    proc_dm_en = 1'b1;
    send_byte(1, 8'h88, 1);
    proc_dm_en = 1'b0;
    for (int i = 0; i < 4; i++) run_cycle(16'(i), 1'b0, 8'h00);
    pulse_end(16'h0000, 16'd4);
    wait_done(1'b1);

    // Randomized jobs; the last one wraps the dump address past 0xFFFF
    for (int j = 0; j < 6; j++) begin
      ll = 16'($urandom_range(1, 12));
      dl = (j == 5) ? 16'd4 : 16'($urandom_range(1, 8));
      db = (j == 5) ? 16'hFFFE : 16'($urandom_range(0, 100));
      start_job(ll, db, dl);
      for (int i = 0; i < int'(ll); i++) send_byte(i, 8'($urandom), int'($urandom_range(0, 2)));
      check("rand_run_entered", proc_status, 2);
      for (int i = 0; i < int'(dl); i++) begin
        a = db + 16'(i) + 16'($urandom_range(0, 15) << 12);
        run_cycle(a, 1'b1, 8'($urandom));
      end
      for (int i = 0; i < 12; i++)
        run_cycle(16'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), 8'($urandom));
      pulse_end(db, dl);
      wait_done(1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dm_host_controller.md
Name: dm_host_controller

Overview:
- Data-memory front end that sits directly beside the processor and owns its byte-wide data memory.
- A host streams matrix operands into memory while the processor is held in reset, then releases the processor.
- The processor reads and writes memory during the run. When the processor raises end_process, the block freezes it and streams a result window back to the host.
- Drives the processor's dm_out, status and reset.

Parameters:
- DATA_WIDTH, 8, memory word and host byte width.
- ADDR_WIDTH, 16, address and length width.
- DEPTH, 4096, memory words. Addresses are taken modulo DEPTH (low log2(DEPTH) bits).

Ports:
- clock  in  1  system clock, rising edge.
- rst_r  in  1  synchronous, active-high reset.
- host_start  in  1  single-cycle job start. Honoured only in IDLE or DONE.
- host_load_len  in  ADDR_WIDTH  bytes to load from address 0. Latched on start.
- host_dump_base  in  ADDR_WIDTH  first address to dump. Latched on start.
- host_dump_len  in  ADDR_WIDTH  bytes to dump. Latched on start.
- host_in_data  in  DATA_WIDTH  load byte.
- host_in_valid  in  1  load byte valid.
- host_in_ready  out  1  block accepts a load byte.
- host_out_data  out  DATA_WIDTH  dump byte.
- host_out_valid  out  1  dump byte valid.
- host_out_ready  in  1  host accepts a dump byte.
- proc_dm_en  in  1  processor write strobe.
- proc_addr  in  ADDR_WIDTH  processor address (AR).
- proc_wdata  in  DATA_WIDTH  processor write data (bus).
- proc_end  in  1  processor end_process.
- proc_rdata  out  DATA_WIDTH  read data to processor dm_out.
- proc_status  out  2  job status to processor status input.
- proc_rst  out  1  processor reset.
- busy  out  1  high in any state other than IDLE or DONE.

Behaviour:
- Interface: one clock, `clock`. Reset `rst_r` is synchronous and active-high.
- Reset values: state IDLE, proc_rst=1, proc_status=00, host_in_ready=0, host_out_valid=0, host_out_data=0, proc_rdata=0, busy=0. All counters are cleared.
- Memory contents are never cleared by reset.
- Reset mid-operation aborts the job and returns to IDLE next edge. Any byte in flight is dropped.
- Memory: single byte array, synchronous write, registered read with 1-cycle latency.
- States and proc_status encoding: IDLE=00, LOAD=01, RUN=10, DUMP_RD=11, DUMP_OUT=11, DONE=11.
- proc_rst is registered. It is 0 only while the state is RUN.
- IDLE/DONE, on host_start:
  - Latch the three length/base inputs and clear cnt.
  - Go to LOAD, or to RUN if load_len==0.
- LOAD:
  - host_in_ready=1.
  - A transfer occurs when valid&ready at a rising edge. It writes mem[cnt]=host_in_data and increments cnt.
  - When the accepted byte is number load_len, go to RUN next edge. host_in_ready drops in that same cycle.
- RUN:
  - The processor owns memory.
  - proc_dm_en=1 writes mem[proc_addr]=proc_wdata.
  - Each cycle, proc_rdata <= mem[proc_addr]. The read is continuous; on a same-address write, old data is returned.
  - On proc_end=1: clear cnt and go to DUMP_RD, or to DONE if dump_len==0. proc_rst rises at that edge.
- Processor ownership outside RUN:
  - proc_dm_en is ignored.
  - proc_rdata keeps updating from proc_addr.
- DUMP_RD: issue read at host_dump_base+cnt (ADDR_WIDTH wrap, then modulo DEPTH). Go to DUMP_OUT.
- DUMP_OUT:
  - host_out_valid=1. host_out_data holds the read byte, stable until accepted.
  - On valid&ready: cnt++. If cnt reaches dump_len, go to DONE; otherwise go to DUMP_RD.
  - Throughput is one byte per 2 cycles minimum.
- DONE: holds until host_start, which begins a new job exactly as from IDLE.
- host_start outside IDLE/DONE is ignored, including any new length/base values.
- A host_start pulse with simultaneous host_in_valid does not transfer that byte. Loading begins the cycle after LOAD is entered.

Test Plan:
- Reset: assert rst_r 2 cycles mid-stream -> proc_rst=1, proc_status=00, host_in_ready=0, host_out_valid=0, busy=0.
- Load: start with load_len=4. Send 0x11,0x22,0x33,0x44 with valid gaps of 0/2/1 cycles -> mem[0..3] hold those bytes and status is 01 during load. One cycle after the 4th accept, status=10 and proc_rst=0.
- Run access: in RUN, write proc_addr=0x0010, proc_wdata=0xAB with dm_en. Then read proc_addr=0x0001 -> proc_rdata=0x22 one cycle later. Reading 0x0010 -> 0xAB.
- Dump with stall: dump_base=0x0010, dump_len=2, mem[0x11]=0xCD. Pulse proc_end and hold host_out_ready low 3 cycles -> host_out_data=0xAB stable and valid held. Then 0xCD is output, then status=11, busy=0, proc_rst=1.
- Zero lengths and ignored start: load_len=0 -> RUN the cycle after start. dump_len=0 -> DONE the cycle after proc_end. host_start during RUN with new lengths -> no state or latch change.
- Abort: rst_r during LOAD after 2 bytes -> IDLE. A new job with load_len=2 overwrites mem[0..1]; mem[2..3] keep their prior data.
